// File: rtl/seg_pkg.sv
// Shared types, segment patterns and the digit decoder for the seven-segment
// scan controller.
package seg_pkg;

  // {a,b,c,d,e,f,g,dp}, active-low
  typedef logic [7:0] seg_t;

  // Blink half-period the display is currently in
  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } blink_phase_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Segment patterns a..g, active-low (dp handled separately)
  localparam logic [6:0] PAT_OFF = 7'b1111111;
  localparam logic [6:0] PAT_0   = 7'b0000001;
  localparam logic [6:0] PAT_1   = 7'b1001111;
  localparam logic [6:0] PAT_2   = 7'b0010010;
  localparam logic [6:0] PAT_3   = 7'b0000110;
  localparam logic [6:0] PAT_4   = 7'b1001100;
  localparam logic [6:0] PAT_5   = 7'b0100100;
  localparam logic [6:0] PAT_6   = 7'b1100000;
  localparam logic [6:0] PAT_7   = 7'b0001111;
  localparam logic [6:0] PAT_8   = 7'b0000000;
  localparam logic [6:0] PAT_9   = 7'b0001100;
  localparam logic [6:0] PAT_H   = 7'b1001000;
  localparam logic [6:0] PAT_I   = 7'b1001111;
  localparam logic [6:0] PAT_E   = 7'b0110000;
  localparam logic [6:0] PAT_L   = 7'b1110001;
  localparam logic [6:0] PAT_P   = 7'b0011000;

  // Map a 4-bit code to segments; unknown codes go dark, dp is independent
  function automatic seg_t seg_decode(input logic [3:0] code,
                                      input logic       ltr,
                                      input logic       dp);
    logic [6:0] pat;
    pat = PAT_OFF;
    if (ltr) begin
      case (code)
        4'h5:    pat = PAT_H;
        4'hA:    pat = PAT_I;
        4'hE:    pat = PAT_E;
        4'h1:    pat = PAT_L;
        4'hB:    pat = PAT_P;
        default: pat = PAT_OFF;
      endcase
    end else begin
      case (code)
        4'h0:    pat = PAT_0;
        4'h1:    pat = PAT_1;
        4'h2:    pat = PAT_2;
        4'h3:    pat = PAT_3;
        4'h4:    pat = PAT_4;
        4'h5:    pat = PAT_5;
        4'h6:    pat = PAT_6;
        4'h7:    pat = PAT_7;
        4'h8:    pat = PAT_8;
        4'h9:    pat = PAT_9;
        default: pat = PAT_OFF;
      endcase
    end
    return {pat, ~dp};
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Image-load / display bus between board status logic (master) and the
// scan controller (slave).
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]   ltr_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic [NUM_DIGITS-1:0]   blink_i;
  logic                    load_i;
  logic                    pending_o;
  logic                    frame_o;
  seg_t                    seg_o;
  logic [NUM_DIGITS-1:0]   an_o;

  modport master (
    output digits_i, ltr_i, dp_i, blank_i, blink_i, load_i,
    input  pending_o, frame_o, seg_o, an_o
  );

  modport slave (
    input  digits_i, ltr_i, dp_i, blank_i, blink_i, load_i,
    output pending_o, frame_o, seg_o, an_o
  );

endinterface

// File: rtl/seg_digit_decode.sv
// Combinational decoder for the currently scanned digit.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       ltr,
  input  logic       dp,
  output seg_t       seg
);

  // Pure lookup through the shared package decoder
  always_comb begin
    seg = seg_decode(code, ltr, dp);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered
// image committed only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 50
)(
  input  logic         clk_i,
  input  logic         rst_i,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blink_cnt;
  blink_phase_t     blink_phase;

  logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
  logic [NUM_DIGITS-1:0]   sh_ltr, act_ltr;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
  logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
  logic [NUM_DIGITS-1:0]   sh_blink, act_blink;

  logic refresh_term;
  logic last_idx;
  logic frame_edge;

  logic [3:0]            cur_code;
  logic                  cur_ltr;
  logic                  cur_dp;
  logic                  cur_dark;
  logic [NUM_DIGITS-1:0] an_lit;
  seg_t                  dec_seg;

  // Terminal-count and frame-boundary detection
  always_comb begin
    refresh_term = (cnt == CNT_W'(REFRESH_DIV - 1));
    last_idx     = (idx == IDX_W'(NUM_DIGITS - 1));
    frame_edge   = refresh_term && last_idx;
  end

  // Refresh counter and scanned digit index
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (refresh_term) begin
      cnt <= '0;
      idx <= last_idx ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow/active image, pending flag, frame pulse and blink timing.
  // A load on a boundary edge: the commit reads the pre-edge shadow (NBA),
  // and load taking priority keeps pending set for the new data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_digits     <= '0;
      sh_ltr        <= '0;
      sh_dp         <= '0;
      sh_blank      <= '1;
      sh_blink      <= '0;
      act_digits    <= '0;
      act_ltr       <= '0;
      act_dp        <= '0;
      act_blank     <= '1;
      act_blink     <= '0;
      bus.pending_o <= 1'b0;
      bus.frame_o   <= 1'b0;
      blink_cnt     <= '0;
      blink_phase   <= PH_ON;
    end else begin
      bus.frame_o <= frame_edge;
      if (frame_edge && bus.pending_o) begin
        act_digits <= sh_digits;
        act_ltr    <= sh_ltr;
        act_dp     <= sh_dp;
        act_blank  <= sh_blank;
        act_blink  <= sh_blink;
      end
      if (bus.load_i) begin
        sh_digits     <= bus.digits_i;
        sh_ltr        <= bus.ltr_i;
        sh_dp         <= bus.dp_i;
        sh_blank      <= bus.blank_i;
        sh_blink      <= bus.blink_i;
        bus.pending_o <= 1'b1;
      end else if (frame_edge) begin
        bus.pending_o <= 1'b0;
      end
      if (frame_edge) begin
        if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= (blink_phase == PH_ON) ? PH_OFF : PH_ON;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Select the active-image fields of the scanned digit
  always_comb begin
    cur_code = '0;
    cur_ltr  = 1'b0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    an_lit   = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_code  = act_digits[4*k +: 4];
        cur_ltr   = act_ltr[k];
        cur_dp    = act_dp[k];
        cur_dark  = act_blank[k] | (act_blink[k] & (blink_phase == PH_OFF));
        an_lit[k] = 1'b0;
      end
    end
  end

  seg_digit_decode u_dec (
    .code (cur_code),
    .ltr  (cur_ltr),
    .dp   (cur_dp),
    .seg  (dec_seg)
  );

  // Registered display pins
  always_ff @(posedge clk_i) begin
    if (rst_i || cur_dark) begin
      bus.seg_o <= SEG_BLANK;
      bus.an_o  <= '1;
    end else begin
      bus.seg_o <= dec_seg;
      bus.an_o  <= an_lit;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4-cycle refresh, 2-frame blink.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  ltr;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [31:0] seg;  // byte k = expected seg_o for digit k
    logic [15:0] an;   // nibble k = expected an_o for digit k
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Advance to the next negedge on which frame_o is high (bounded)
  task automatic wait_frame(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_o !== 1'b1 && n < 64);
    check({nm, " frame_wait"}, {31'b0, bus.frame_o}, 32'd1);
  endtask

  // Called at the negedge where frame_o is high; samples each digit mid-slot
  task automatic check_image(input string nm, input logic [31:0] seg, input logic [15:0] an);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clk);
      check($sformatf("%s seg d%0d", nm, k), {24'b0, bus.seg_o}, {24'b0, seg[8*k +: 8]});
      check($sformatf("%s an d%0d", nm, k), {28'b0, bus.an_o}, {28'b0, an[4*k +: 4]});
    end
  endtask

  // Drive an image with a one-cycle load strobe; returns at the following negedge
  task automatic do_load(input logic [15:0] d, input logic [3:0] l, input logic [3:0] p,
                         input logic [3:0] b, input logic [3:0] bl);
    bus.digits_i = d;
    bus.ltr_i    = l;
    bus.dp_i     = p;
    bus.blank_i  = b;
    bus.blink_i  = bl;
    bus.load_i   = 1'b1;
    @(negedge clk);
    bus.load_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    int first_pulse;
    int last_pulse;
    int gap_bad;
    int dark_bad;

    bus.digits_i = '0;
    bus.ltr_i    = '0;
    bus.dp_i     = '0;
    bus.blank_i  = '0;
    bus.blink_i  = '0;
    bus.load_i   = 1'b0;

    vecs[0] = '{16'h3210, 4'b0000, 4'b0000, 4'b0000, 32'h0D259F03, 16'h7BDE};
    vecs[1] = '{16'h005A, 4'b0011, 4'b0001, 4'b0000, 32'h0303919E, 16'h7BDE};
    vecs[2] = '{16'h9876, 4'b0000, 4'b1010, 4'b0000, 32'h18011EC1, 16'h7BDE};
    vecs[3] = '{16'hB1E5, 4'b1111, 4'b0000, 4'b0000, 32'h31E36191, 16'h7BDE};
    vecs[4] = '{16'hCAF4, 4'b0000, 4'b0010, 4'b0101, 32'hFFFFFEFF, 16'h7FDF};
    vecs[5] = '{16'h7203, 4'b1100, 4'b0000, 4'b0000, 32'hFFFF030D, 16'h7BDE};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst seg", {24'b0, bus.seg_o}, 32'hFF);
    check("rst an", {28'b0, bus.an_o}, 32'hF);
    check("rst pending", {31'b0, bus.pending_o}, 32'd0);
    check("rst frame", {31'b0, bus.frame_o}, 32'd0);
    rst = 1'b0;

    // Idle after reset: dark display, frame_o every 16 cycles
    pulses = 0; first_pulse = 0; last_pulse = 0; gap_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check($sformatf("idle seg c%0d", c), {24'b0, bus.seg_o}, 32'hFF);
      check($sformatf("idle an c%0d", c), {28'b0, bus.an_o}, 32'hF);
      if (bus.frame_o === 1'b1) begin
        if (pulses == 0) first_pulse = c;
        else if (c - last_pulse != 16) gap_bad++;
        last_pulse = c;
        pulses++;
      end
    end
    check("idle frame count", pulses, 2);
    check("idle first frame", first_pulse, 16);
    check("idle frame gap", gap_bad, 0);

    // Table: load after a frame, commit at the next, then check the scan
    wait_frame("sync");
    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].digits, vecs[v].ltr, vecs[v].dp, vecs[v].blank, 4'b0000);
      check($sformatf("v%0d pending set", v), {31'b0, bus.pending_o}, 32'd1);
      wait_frame($sformatf("v%0d", v));
      check($sformatf("v%0d pending clr", v), {31'b0, bus.pending_o}, 32'd0);
      check_image($sformatf("v%0d", v), vecs[v].seg, vecs[v].an);
      wait_frame($sformatf("v%0d next", v));
    end

    // Load on the frame-boundary edge: old shadow commits, pending stays set
    do_load(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (14) @(negedge clk);
    do_load(16'h9876, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
    check("bnd frame", {31'b0, bus.frame_o}, 32'd1);
    check("bnd pending", {31'b0, bus.pending_o}, 32'd1);
    check_image("bnd old", vecs[0].seg, vecs[0].an);
    wait_frame("bnd");
    check("bnd pending clr", {31'b0, bus.pending_o}, 32'd0);
    check_image("bnd new", vecs[2].seg, vecs[2].an);

    // Reset mid-frame with an image pending
    wait_frame("rst sync");
    do_load(16'h8888, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    check("mid pending", {31'b0, bus.pending_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst pending", {31'b0, bus.pending_o}, 32'd0);
    check("mid rst seg", {24'b0, bus.seg_o}, 32'hFF);
    check("mid rst an", {28'b0, bus.an_o}, 32'hF);
    check("mid rst frame", {31'b0, bus.frame_o}, 32'd0);
    dark_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.seg_o !== 8'hFF || bus.an_o !== 4'hF) dark_bad++;
    end
    check("post rst dark cycles", dark_bad, 0);

    // Blink on digit 0 from a fresh reset: lit, dark, dark, lit, lit
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_load(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    for (int f = 1; f <= 5; f++) begin
      wait_frame($sformatf("blink f%0d", f));
      if (f == 2 || f == 3)
        check_image($sformatf("blink f%0d", f), 32'h0D259FFF, 16'h7BDF);
      else
        check_image($sformatf("blink f%0d", f), 32'h0D259F03, 16'h7BDE);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
